// File: rtl/rat_reduce.sv
// Reduces a signed rational num/den to lowest terms. A binary GCD runs first,
// then two restoring dividers produce |num|/g and den/g together.
module rat_reduce #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   input  logic [WIDTH-1:0] in_den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_num,
   output logic [WIDTH-1:0] out_den,
   output logic             out_err
);
   localparam int KW = $clog2(WIDTH) + 1;
   localparam logic [KW-1:0]    K_ONE = KW'(1);
   localparam logic [KW-1:0]    LAST  = KW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

   state_t           state_q;
   logic             sign_q;
   logic [WIDTH-1:0] a_q, b_q, g_q;
   logic [KW-1:0]    k_q, cnt_q;
   logic [WIDTH-1:0] dvd_num_q, dvd_den_q, rem_num_q, rem_den_q;
   logic [WIDTH-1:0] dvd_num_d, dvd_den_d, rem_num_d, rem_den_d;
   logic [WIDTH-1:0] out_num_q, out_den_q;
   logic             out_valid_q, out_err_q;
   logic [WIDTH:0]   trial_num, trial_den;
   logic             fit_num, fit_den;
   logic [WIDTH-1:0] abs_in;

   // Dividend registers shift left while quotient bits enter at the LSB, so
   // after WIDTH steps they hold the quotients.
   always_comb begin
      abs_in    = in_num[WIDTH-1] ? (~in_num + ONE) : in_num;
      trial_num = {rem_num_q, dvd_num_q[WIDTH-1]};
      trial_den = {rem_den_q, dvd_den_q[WIDTH-1]};
      fit_num   = trial_num >= {1'b0, g_q};
      fit_den   = trial_den >= {1'b0, g_q};
      rem_num_d = fit_num ? WIDTH'(trial_num - {1'b0, g_q}) : trial_num[WIDTH-1:0];
      rem_den_d = fit_den ? WIDTH'(trial_den - {1'b0, g_q}) : trial_den[WIDTH-1:0];
      dvd_num_d = {dvd_num_q[WIDTH-2:0], fit_num};
      dvd_den_d = {dvd_den_q[WIDTH-2:0], fit_den};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         g_q         <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         dvd_num_q   <= '0;
         dvd_den_q   <= '0;
         rem_num_q   <= '0;
         rem_den_q   <= '0;
         out_num_q   <= '0;
         out_den_q   <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q    <= in_num[WIDTH-1];
                  a_q       <= abs_in;
                  b_q       <= in_den;
                  k_q       <= '0;
                  dvd_num_q <= abs_in;
                  dvd_den_q <= in_den;
                  rem_num_q <= '0;
                  rem_den_q <= '0;
                  if (in_den == '0) begin
                     out_num_q   <= in_num;
                     out_den_q   <= '0;
                     out_err_q   <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     state_q <= GCD;
                  end
               end
            end
            GCD: begin
               if (a_q == '0 || b_q == '0) begin
                  g_q     <= (a_q | b_q) << k_q;
                  cnt_q   <= '0;
                  state_q <= DIV;
               end else if (!a_q[0] && !b_q[0]) begin
                  a_q <= a_q >> 1;
                  b_q <= b_q >> 1;
                  k_q <= k_q + K_ONE;
               end else if (!a_q[0]) begin
                  a_q <= a_q >> 1;
               end else if (!b_q[0]) begin
                  b_q <= b_q >> 1;
               end else if (a_q >= b_q) begin
                  a_q <= a_q - b_q;
               end else begin
                  b_q <= b_q - a_q;
               end
            end
            DIV: begin
               rem_num_q <= rem_num_d;
               rem_den_q <= rem_den_d;
               dvd_num_q <= dvd_num_d;
               dvd_den_q <= dvd_den_d;
               cnt_q     <= cnt_q + K_ONE;
               if (cnt_q == LAST) begin
                  out_num_q   <= sign_q ? (~dvd_num_d + ONE) : dvd_num_d;
                  out_den_q   <= dvd_den_d;
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // g divides both operands, so a nonzero remainder means the GCD went wrong.
   always_ff @(posedge clk) begin
      if (!rst && state_q == DIV && cnt_q == LAST)
         assert (rem_num_d == '0 && rem_den_d == '0);
   end
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_num   = out_num_q;
   assign out_den   = out_den_q;
   assign out_err   = out_err_q;
endmodule

// File: tb/tb_rat_reduce.sv
// Bench for rat_reduce: directed table, handshake/reset corner sequences and
// random operands checked against a Euclid-based reference model.
module tb_rat_reduce;
   localparam int W       = 32;
   localparam int LAT_MAX = 4 * W + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, out_err;
   logic [W-1:0] in_num, in_den, out_num, out_den;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] num;
      logic [W-1:0] den;
      logic [W-1:0] exp_num;
      logic [W-1:0] exp_den;
      logic         exp_err;
   } vec_t;

   vec_t tbl[13];

   rat_reduce #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_num(in_num), .in_den(in_den),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_num(out_num), .out_den(out_den), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Reference: Euclid's algorithm on 64-bit magnitudes.
   function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                 output logic [W-1:0] en, output logic [W-1:0] ed,
                                 output logic ee);
      longint unsigned a, x, y, t, q, g;
      logic [63:0] s;
      if (d == '0) begin
         en = n; ed = '0; ee = 1'b1;
         return;
      end
      a = n[W-1] ? ((64'd1 << W) - {32'd0, n}) : {32'd0, n};
      x = a;
      y = {32'd0, d};
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      g  = x;
      q  = a / g;
      s  = n[W-1] ? (64'd0 - q) : q;
      en = s[W-1:0];
      ed = W'({32'd0, d} / g);
      ee = 1'b0;
   endfunction

   task automatic wait_out(input string tag, output int lat);
      lat = 1;
      while (!out_valid && lat <= LAT_MAX) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         n_vec++; n_bad++;
         $display("FAIL %s_timeout: out_valid 0 after %0d cycles, expected 1", tag, lat);
      end
   endtask

   task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] rn, output logic [W-1:0] rd,
                         output logic re, output int lat);
      int waited = 0;
      @(negedge clk);
      in_num = n; in_den = d; in_valid = 1'b1;
      while (!in_ready && waited < LAT_MAX) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_vec++; n_bad++;
         $display("FAIL accept_timeout: in_ready 0, expected 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_out("op", lat);
      rn = out_num; rd = out_den; re = out_err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic apply(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [W-1:0] en, input logic [W-1:0] ed, input logic ee);
      logic [W-1:0] rn, rd;
      logic         re;
      int           lat;
      run_op(n, d, rn, rd, re, lat);
      $display("%s: %h/%h -> %h/%h err=%0b lat=%0d", tag, n, d, rn, rd, re, lat);
      chk({tag, "_num"}, rn, en);
      chk({tag, "_den"}, rd, ed);
      chk({tag, "_err"}, W'(re), W'(ee));
      n_vec++;
      if (ee ? (lat != 1) : (lat <= W || lat > LAT_MAX)) begin
         n_bad++;
         $display("FAIL %s_latency: got %0d, expected %s", tag, lat,
                  ee ? "1" : "within (W, 4W+2]");
      end
   endtask

   initial begin
      logic [W-1:0] rn, rd, en, ed, n, d, m;
      logic         ee, seen;
      int           lat;

      in_valid = 1'b0; in_num = '0; in_den = '0; out_ready = 1'b0; rst = 1'b1;

      tbl[0]  = '{32'd6,        32'd8,        32'd3,        32'd4,        1'b0};
      tbl[1]  = '{32'hFFFFFFF6, 32'd4,        32'hFFFFFFFB, 32'd2,        1'b0};
      tbl[2]  = '{32'd0,        32'd7,        32'd0,        32'd1,        1'b0};
      tbl[3]  = '{32'd5,        32'd0,        32'd5,        32'd0,        1'b1};
      tbl[4]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd1,        1'b0};
      tbl[5]  = '{32'd7,        32'd13,       32'd7,        32'd13,       1'b0};
      tbl[6]  = '{32'd9,        32'd3,        32'd3,        32'd1,        1'b0};
      tbl[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd1,        1'b0};
      tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      tbl[9]  = '{32'hFFFFFFF4, 32'd18,       32'hFFFFFFFE, 32'd3,        1'b0};
      tbl[10] = '{32'd0,        32'd0,        32'd0,        32'd0,        1'b1};
      tbl[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        32'd1,        1'b0};
      tbl[12] = '{32'hFFFFFFF6, 32'd0,        32'hFFFFFFF6, 32'd0,        1'b1};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_out_num", out_num, '0);
      chk("rst_out_den", out_den, '0);
      chk("rst_out_err", W'(out_err), '0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", W'(in_ready), W'(1));

      for (int i = 0; i < 13; i++)
         apply($sformatf("tbl%0d", i), tbl[i].num, tbl[i].den,
               tbl[i].exp_num, tbl[i].exp_den, tbl[i].exp_err);

      // Result must hold steady while the consumer stalls.
      @(negedge clk);
      in_num = 32'd6; in_den = 32'd8; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out("hold", lat);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", W'(out_valid), W'(1));
         chk("hold_num", out_num, 32'd3);
         chk("hold_den", out_den, 32'd4);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_drop_valid", W'(out_valid), '0);
      chk("hold_in_ready", W'(in_ready), W'(1));
      $display("hold: 6/8 stalled 5 cycles then released");

      // in_valid held high across two operands.
      in_num = 32'd4; in_den = 32'd6; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_busy", W'(in_ready), '0);
      in_num = 32'd10; in_den = 32'd25;
      wait_out("b2b1", lat);
      chk("b2b_busy_done", W'(in_ready), '0);
      chk("b2b1_num", out_num, 32'd2);
      chk("b2b1_den", out_den, 32'd3);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_bubble_valid", W'(out_valid), '0);
      chk("b2b_ready_again", W'(in_ready), W'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_second_busy", W'(in_ready), '0);
      wait_out("b2b2", lat);
      chk("b2b2_num", out_num, 32'd2);
      chk("b2b2_den", out_den, 32'd5);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("b2b: 4/6 then 10/25 with in_valid held high");

      // Reset while the dividers are running must drop the operation.
      in_num = 32'd12; in_den = 32'd18; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_valid", W'(out_valid), '0);
      chk("abort_rst_ready", W'(in_ready), W'(1));
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_output", W'(seen), '0);
      chk("abort_ready", W'(in_ready), W'(1));
      $display("abort: reset pulsed during 12/18");
      apply("post_abort", 32'd9, 32'd3, 32'd3, 32'd1, 1'b0);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               n = $urandom;
               d = $urandom;
            end
            1: begin
               m = $urandom_range(1, 5000);
               n = m * $urandom_range(0, 4000);
               d = m * $urandom_range(1, 4000);
               if ($urandom_range(0, 1) == 1) n = ~n + 32'd1;
            end
            default: begin
               n = $urandom << $urandom_range(0, 20);
               d = 32'd1 << $urandom_range(0, 31);
            end
         endcase
         if (d == '0) d = 32'd1;
         model(n, d, en, ed, ee);
         apply($sformatf("rnd%0d", i), n, d, en, ed, ee);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
